fact_responder: RTL and testbench
=================================

// Module: fact_responder
// PURPOSE
//  Memory-mapped bus responder for the factorial accelerator: decodes master
//  accesses (select/write/address/write-data), keeps the control, status and
//  result registers, and computes N! iteratively into a 128-bit result.
//  It sits behind the top-level address decoder at the 0x7000 window.
//  It raises interrupt on completion when interrupts are enabled.
// PARAMETERS
//  ADDR_W    8  offset bits decoded (window base stripped by the top level)
//  MUL_BITS  2  multiplier bits retired per MUL cycle; must divide 64
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    synchronous, active-high reset
//  s_sel     in   1    access strobe from address decoder, one access per cycle
//  s_wr      in   1    1 = write, 0 = read (valid with s_sel)
//  s_addr    in   ADDR_W  byte offset within window
//  s_din     in   64   write data from master
//  s_dout    out  64   read data to master, registered
//  interrupt out  1    done & intr_en, registered
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high.
//  Map: 0x00 opstart(W), 0x08 opclear(W), 0x10 opdone(R: bit0 done, bit1 busy),
//   0x18 intr_en(RW bit0), 0x20 operand(RW 64b), 0x28 result_h(R), 0x30 result_l(R).
//   Unmapped offsets and write-only registers read 0; writes to RO regs ignored.
//  Reset: s_dout=0, interrupt=0, operand=0, intr_en=0, result=0, state=IDLE.
//  Read: s_sel&!s_wr at edge t -> s_dout holds the register at edge t+1;
//   s_dout holds its last value when there is no read.
//  States: IDLE, LOAD, MUL, DONE.
//   IDLE: write with bit0=1 to opstart -> LOAD (k=operand, product=1);
//    if operand<=1 -> DONE directly, result=1.
//   LOAD: 1 cycle; latch k as multiplier, clear accumulator -> MUL.
//   MUL: 64/MUL_BITS cycles of shift-add, product*k truncated mod 2^128;
//    then k-1; if new k>=2 -> LOAD, else result<=product -> DONE.
//   DONE: done=1; held until opclear.
//  Latency, counted from the edge that samples opstart to done=1: 1 if N<=1,
//   else (64/MUL_BITS+1)*(N-1) (33*(N-1) at default).
//  busy=1 in LOAD/MUL. result_h/result_l hold the previous value until DONE.
//  Overflow: N>34 wraps mod 2^128, no flag. Operand is a full 64-bit value.
//  opclear write with bit0=1 (any state, incl. mid-compute): -> IDLE, result=0,
//   done=0, interrupt=0 next edge; operand and intr_en kept.
//   Same-cycle opstart is impossible: one access per cycle.
//  opstart while busy/DONE: ignored. Writes to operand while busy are ignored.
//   Writes to intr_en always take effect.
//  interrupt = done & intr_en, so enabling intr_en while in DONE raises it
//   on the next edge.
//  reset mid-compute: all state to reset values on that edge.
// TESTING
//  1 operand=16, intr_en=0, opstart=1; poll opdone -> done at edge 495;
//    result_h=0, result_l=0x0000_1307_7775_8000, interrupt stays 0.
//  2 opclear; operand=7, intr_en=1, start -> done at 198; result_l=0x13B0;
//    interrupt=1 until opclear, then 0 next cycle.
//  3 operand=21 -> result_h=0x2, result_l=0xC507_7D36_B8C4_0000.
//  4 operand=0 and operand=1 -> done after 1 edge, result_l=1, result_h=0.
//  5 operand=16, start, opclear at edge 100 -> busy=0, done=0, result=0;
//    a second start runs to 16! again; an operand write mid-run is ignored.
//  6 reset asserted mid-MUL -> all outputs 0 next edge; unmapped read 0x40 -> 0.

Source files
------------

// File: rtl/fact_responder.sv
// fact_responder: bus-mapped factorial accelerator computing N! mod 2^128.
// Ports: clk; reset (sync, active-high); s_sel/s_wr/s_addr/s_din access in;
//   s_dout registered read data; interrupt = done & intr_en (registered).
module fact_responder #(
   parameter int ADDR_W   = 8,
   parameter int MUL_BITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_sel,
   input  logic              s_wr,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [63:0]       s_din,
   output logic [63:0]       s_dout,
   output logic              interrupt
);

   localparam int CYC = 64 / MUL_BITS;
   localparam int CW  = (CYC > 1) ? $clog2(CYC) : 1;

   localparam logic [ADDR_W-1:0] A_START = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_CLEAR = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_INTR  = ADDR_W'(8'h18);
   localparam logic [ADDR_W-1:0] A_OPND  = ADDR_W'(8'h20);
   localparam logic [ADDR_W-1:0] A_RESH  = ADDR_W'(8'h28);
   localparam logic [ADDR_W-1:0] A_RESL  = ADDR_W'(8'h30);

   typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [63:0]    r_operand;
   logic           r_intr_en;
   logic [127:0]   r_result;
   logic [127:0]   r_prod;
   logic [63:0]    r_k;
   logic [63:0]    r_mult;
   logic [127:0]   r_mcand;
   logic [127:0]   r_acc;
   logic [CW-1:0]  r_cnt;
   logic [63:0]    r_dout;
   logic           r_irq;

   logic           w_wr;
   logic           w_rd;
   logic           w_start;
   logic           w_clear;
   logic           w_busy;
   logic           w_done;
   logic           w_last;
   logic           w_intr_nxt;
   logic [63:0]    w_k_dec;
   logic [127:0]   w_pp;
   logic [127:0]   w_acc_nxt;
   logic [63:0]    w_rdata;

   assign w_wr      = s_sel & s_wr;
   assign w_rd      = s_sel & ~s_wr;
   assign w_start   = w_wr && (s_addr == A_START) && s_din[0];
   assign w_clear   = w_wr && (s_addr == A_CLEAR) && s_din[0];
   assign w_busy    = (r_state == LOAD) || (r_state == MUL);
   assign w_done    = (r_state == DONE);
   assign w_last    = (r_cnt == CW'(CYC - 1));
   assign w_k_dec   = r_k - 64'd1;
   assign w_acc_nxt = r_acc + w_pp;

   // intr_en as it will be after this edge, so interrupt tracks it
   // on the same edge that done or intr_en changes.
   assign w_intr_nxt = (w_wr && (s_addr == A_INTR)) ? s_din[0] : r_intr_en;

   // Partial product for the MUL_BITS multiplier bits retired this cycle;
   // r_mcand is pre-shifted so the digit weight is already applied.
   always_comb begin
      w_pp = '0;
      for (int b = 0; b < MUL_BITS; b++) begin
         if (r_mult[b]) w_pp = w_pp + (r_mcand << b);
      end
   end

   always_comb begin
      w_next = r_state;
      if (w_clear) begin
         w_next = IDLE;
      end else begin
         unique case (r_state)
            IDLE: if (w_start) w_next = (r_operand <= 64'd1) ? DONE : LOAD;
            LOAD: w_next = MUL;
            MUL:  if (w_last) w_next = (w_k_dec >= 64'd2) ? LOAD : DONE;
            DONE: w_next = DONE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      unique case (s_addr)
         A_STAT:  w_rdata = {62'd0, w_busy, w_done};
         A_INTR:  w_rdata = {63'd0, r_intr_en};
         A_OPND:  w_rdata = r_operand;
         A_RESH:  w_rdata = r_result[127:64];
         A_RESL:  w_rdata = r_result[63:0];
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_operand <= '0;
         r_intr_en <= 1'b0;
         r_result  <= '0;
         r_prod    <= '0;
         r_k       <= '0;
         r_mult    <= '0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_dout    <= '0;
         r_irq     <= 1'b0;
      end else begin
         if (w_rd) r_dout <= w_rdata;
         if (w_wr && (s_addr == A_INTR)) r_intr_en <= s_din[0];
         if (w_wr && (s_addr == A_OPND) && !w_busy) r_operand <= s_din;
         r_irq <= (w_next == DONE) & w_intr_nxt;
         if (w_clear) begin
            r_result <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_start) begin
                     r_k    <= r_operand;
                     r_prod <= 128'd1;
                     if (r_operand <= 64'd1) r_result <= 128'd1;
                  end
               end
               LOAD: begin
                  r_mult  <= r_k;
                  r_mcand <= r_prod;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
               MUL: begin
                  r_acc   <= w_acc_nxt;
                  r_mcand <= r_mcand << MUL_BITS;
                  r_mult  <= r_mult >> MUL_BITS;
                  r_cnt   <= r_cnt + CW'(1);
                  if (w_last) begin
                     r_prod <= w_acc_nxt;
                     r_k    <= w_k_dec;
                     if (w_k_dec < 64'd2) r_result <= w_acc_nxt;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign s_dout    = r_dout;
   assign interrupt = r_irq;

endmodule

// File: tb/tb_fact_responder.sv
// tb_fact_responder: random + directed bench for fact_responder with a
// cycle-level reference model and a read-data scoreboard.
module tb_fact_responder;

   localparam int PER = 64 / 2 + 1;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        s_sel  = 1'b0;
   logic        s_wr   = 1'b0;
   logic [7:0]  s_addr = '0;
   logic [63:0] s_din  = '0;
   logic [63:0] s_dout;
   logic        interrupt;

   fact_responder #(.ADDR_W(8), .MUL_BITS(2)) dut (
      .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr),
      .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 0;
   logic [63:0] exp_q[$];

   // Reference model: a run started at edge m_s finishes at edge m_de.
   bit           m_run  = 0;
   bit           m_intr = 0;
   int           m_s    = 0;
   int           m_de   = 0;
   logic [63:0]  m_op   = '0;
   logic [63:0]  m_n    = '0;
   logic [127:0] m_fact = '0;

   logic [7:0] addrs[10] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20,
                             8'h28, 8'h30, 8'h38, 8'h40, 8'hF8};

   function automatic logic [127:0] fact(input logic [63:0] n);
      logic [127:0] p = 128'd1;
      for (longint unsigned i = 2; i <= n; i++) p = p * 128'(i);
      return p;
   endfunction

   function automatic bit m_done(input int e);
      return m_run && (e >= m_de);
   endfunction

   function automatic bit m_busy(input int e);
      return m_run && (m_n > 64'd1) && (e >= m_s) && (e < m_de);
   endfunction

   function automatic logic [63:0] m_read(input logic [7:0] a, input int e);
      logic [63:0] v = '0;
      case (a)
         8'h10: v = {62'd0, m_busy(e), m_done(e)};
         8'h18: v = {63'd0, m_intr};
         8'h20: v = m_op;
         8'h28: v = m_done(e) ? m_fact[127:64] : 64'd0;
         8'h30: v = m_done(e) ? m_fact[63:0] : 64'd0;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Apply a write sampled at edge e to the model (state before is e-1).
   function automatic void m_write(input logic [7:0] a, input logic [63:0] d,
                                   input int e);
      case (a)
         8'h00: if (d[0] && !m_run) begin
            m_run  = 1;
            m_s    = e;
            m_n    = m_op;
            m_fact = fact(m_op);
            m_de   = e + ((m_op <= 64'd1) ? 0 : PER * (int'(m_op) - 1));
         end
         8'h08: if (d[0]) m_run = 0;
         8'h18: m_intr = d[0];
         8'h20: if (!m_busy(e - 1)) m_op = d;
         default: ;
      endcase
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] ex);
      nvec++;
      if (act !== ex) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, ex);
      end
   endfunction

   bit          mon_rd;
   logic [63:0] mon_ex;
   always @(posedge clk) begin
      mon_rd = chk_en && s_sel && !s_wr && !reset;
      #1;
      if (mon_rd) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard_empty @cyc %0d: got %h want none",
                     cyc, s_dout);
         end else begin
            mon_ex = exp_q.pop_front();
            chk("s_dout", s_dout, mon_ex);
         end
      end
      if (chk_en)
         chk("interrupt", {63'd0, interrupt}, {63'd0, m_done(cyc) && m_intr});
   end

   task automatic acc(input bit wr, input logic [7:0] a, input logic [63:0] d);
      int e;
      @(negedge clk);
      e = cyc;
      if (!wr) exp_q.push_back(m_read(a, e));
      else m_write(a, d, e + 1);
      s_sel  = 1'b1;
      s_wr   = wr;
      s_addr = a;
      s_din  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         s_sel = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      s_sel  = 1'b0;
      m_run  = 0;
      m_op   = '0;
      m_intr = 0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1;
      chk("rst_dout", s_dout, 64'd0);
      chk("rst_irq", {63'd0, interrupt}, 64'd0);
   endtask

   task automatic poll(input bit rnd);
      int r;
      bit fin = 0;
      for (int i = 0; i < 40 * PER; i++) begin
         r = rnd ? int'($urandom_range(0, 199)) : 199;
         if (r < 4)       acc(1, 8'h20, {$urandom, $urandom});
         else if (r < 8)  acc(1, 8'h18, 64'($urandom_range(0, 1)));
         else if (r < 11) acc(1, 8'h00, 64'd1);
         else if (r < 16) acc(0, addrs[$urandom_range(0, 9)], 64'd0);
         else if (r == 16) acc(1, 8'h08, 64'd1);
         else acc(0, 8'h10, 64'd0);
         if (!m_run || m_done(cyc + 1)) begin
            fin = 1;
            break;
         end
      end
      acc(0, 8'h10, 64'd0);
      if (!fin) begin
         nvec++;
         nerr++;
         $display("FAIL poll_timeout @cyc %0d: got busy want done", cyc);
      end
   endtask

   task automatic run(input logic [63:0] n, input bit ie, input bit rnd);
      acc(1, 8'h08, 64'd1);
      acc(1, 8'h20, n);
      acc(1, 8'h18, {63'd0, ie});
      acc(1, 8'h00, 64'd1);
      poll(rnd);
      acc(0, 8'h28, 64'd0);
      acc(0, 8'h30, 64'd0);
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog @cyc %0d: got running want finished", cyc);
      $fatal(1);
   end

   initial begin
      do_reset();
      foreach (addrs[i]) acc(0, addrs[i], 64'd0);

      run(64'd16, 1'b0, 1'b0);
      run(64'd7, 1'b1, 1'b0);
      idle(3);
      acc(1, 8'h08, 64'd1);
      acc(0, 8'h10, 64'd0);
      idle(2);
      run(64'd21, 1'b0, 1'b0);
      run(64'd0, 1'b1, 1'b0);
      run(64'd1, 1'b0, 1'b0);
      run(64'd2, 1'b1, 1'b0);

      acc(1, 8'h08, 64'd1);
      acc(1, 8'h20, 64'd16);
      acc(1, 8'h00, 64'd1);
      idle(97);
      acc(1, 8'h20, 64'd5);
      acc(0, 8'h20, 64'd0);
      acc(1, 8'h08, 64'd1);
      acc(0, 8'h10, 64'd0);
      acc(0, 8'h28, 64'd0);
      acc(0, 8'h30, 64'd0);
      acc(1, 8'h00, 64'd1);
      idle(40);
      acc(1, 8'h20, 64'd9);
      poll(1'b0);
      acc(0, 8'h30, 64'd0);
      acc(1, 8'h00, 64'd1);
      acc(0, 8'h10, 64'd0);

      acc(1, 8'h08, 64'd1);
      acc(1, 8'h18, 64'd1);
      acc(1, 8'h00, 64'd1);
      idle(50);
      acc(0, 8'h20, 64'd0);
      idle(1);
      do_reset();
      acc(0, 8'h40, 64'd0);
      acc(0, 8'h18, 64'd0);
      acc(0, 8'h20, 64'd0);
      acc(0, 8'h10, 64'd0);

      for (int it = 0; it < 25; it++) begin
         acc(1, 8'h08, 64'd1);
         acc(1, 8'h20, {$urandom, $urandom});
         acc(0, 8'h20, 64'd0);
         run(64'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), 1'b1);
         acc(1, 8'h00, 64'd1);
         acc(0, 8'h10, 64'd0);
         acc(1, 8'h18, 64'($urandom_range(0, 1)));
         acc(0, 8'h30, 64'd0);
         idle(2);
      end

      idle(3);
      if (exp_q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
